// File: rtl/qa_drv_umf_rx_narrow.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : qa_drv_umf_rx_narrow
// Brief    : Pulls UMF chunks from the host FIFO driver into a small buffer and
//            serializes them LSB-first into OUT_WIDTH pieces on a valid/ready
//            stream, with occupancy and throughput counters.
// Revision : 1.0
// ============================================================================
module qa_drv_umf_rx_narrow #(
    parameter int UMF_WIDTH = 128,
    parameter int OUT_WIDTH = 64,
    parameter int N_ENTRIES = 4
) (
    input  logic                         clk,
    input  logic                         resetb,
    input  logic [UMF_WIDTH-1:0]         rx_data,
    input  logic                         rx_rdy,
    output logic                         rx_enable,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last_piece,
    output logic [$clog2(N_ENTRIES):0]   occupancy,
    output logic [31:0]                  n_chunks_in,
    output logic [31:0]                  n_pieces_out
);

    localparam int RATIO = UMF_WIDTH / OUT_WIDTH;
    localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int AW    = $clog2(N_ENTRIES);
    localparam int CW    = AW + 1;

    logic [UMF_WIDTH-1:0] r_mem [N_ENTRIES];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_piece_idx;
    logic [CW-1:0]        r_occ;
    logic [31:0]          r_n_chunks;
    logic [31:0]          r_n_pieces;

    logic                 w_full;
    logic                 w_enq;
    logic                 w_valid;
    logic                 w_last;
    logic                 w_xfer;
    logic [UMF_WIDTH-1:0] w_cur;

    // Full is judged on the registered count only, so a same-cycle last-piece
    // dequeue never opens a slot and out_ready never reaches rx_enable.
    assign w_full    = (r_occ == CW'(N_ENTRIES));
    assign w_enq     = resetb && rx_rdy && !w_full;
    assign rx_enable = w_enq;

    assign w_valid   = (r_occ != '0);
    assign w_cur     = r_mem[r_rd_ptr];
    assign w_last    = (r_piece_idx == PW'(RATIO - 1));
    assign w_xfer    = w_valid && out_ready;

    assign out_valid      = w_valid;
    assign out_data       = w_cur[r_piece_idx * OUT_WIDTH +: OUT_WIDTH];
    assign out_last_piece = w_valid && w_last;
    assign occupancy      = r_occ;
    assign n_chunks_in    = r_n_chunks;
    assign n_pieces_out   = r_n_pieces;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_piece_idx <= '0;
            r_occ       <= '0;
            r_n_chunks  <= '0;
            r_n_pieces  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_n_chunks <= r_n_chunks + 32'd1;
            end
            if (w_xfer) begin
                r_n_pieces <= r_n_pieces + 32'd1;
                if (w_last) begin
                    r_piece_idx <= '0;
                    r_rd_ptr    <= r_rd_ptr + 1'b1;
                end else begin
                    r_piece_idx <= r_piece_idx + 1'b1;
                end
            end
            case ({w_enq, w_xfer && w_last})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qa_drv_umf_rx_narrow.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_qa_drv_umf_rx_narrow
// Brief    : Directed bench with a piece-level scoreboard for the UMF narrowing
//            receive buffer.
// Revision : 1.0
// ============================================================================
module tb_qa_drv_umf_rx_narrow;

    localparam int UW    = 128;
    localparam int OW    = 64;
    localparam int NE    = 4;
    localparam int RATIO = UW / OW;

    typedef struct {
        logic [OW-1:0] d;
        logic          last;
    } piece_t;

    logic          clk;
    logic          resetb;
    logic [UW-1:0] rx_data;
    logic          rx_rdy;
    logic          rx_enable;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last_piece;
    logic [2:0]    occupancy;
    logic [31:0]   n_chunks_in;
    logic [31:0]   n_pieces_out;

    piece_t        q[$];
    int            m_occ;
    logic [31:0]   m_cin;
    logic [31:0]   m_pout;
    int            checks;
    int            failures;

    qa_drv_umf_rx_narrow #(
        .UMF_WIDTH (UW),
        .OUT_WIDTH (OW),
        .N_ENTRIES (NE)
    ) u_dut (
        .clk            (clk),
        .resetb         (resetb),
        .rx_data        (rx_data),
        .rx_rdy         (rx_rdy),
        .rx_enable      (rx_enable),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last_piece (out_last_piece),
        .occupancy      (occupancy),
        .n_chunks_in    (n_chunks_in),
        .n_pieces_out   (n_pieces_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream treats a pull without an available chunk as fatal.
    always @(negedge clk) begin
        if (resetb === 1'b1 && rx_enable === 1'b1 && rx_rdy !== 1'b1) begin
            $display("FAIL rx_enable_without_rx_rdy observed=1 required=0");
            $fatal(1, "rx_enable asserted without rx_rdy");
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_occ  = 0;
        m_cin  = '0;
        m_pout = '0;
    endtask

    // One clock cycle: compare DUT outputs against the model mid-cycle, then
    // advance the model to match the coming edge.
    task automatic cycle(output logic enq);
        piece_t p;
        @(negedge clk);
        enq = rx_rdy && (m_occ != NE);
        chk("rx_enable", rx_enable, enq);
        chk("out_valid", out_valid, q.size() != 0);
        chk("occupancy", occupancy, m_occ);
        chk("n_chunks_in", n_chunks_in, m_cin);
        chk("n_pieces_out", n_pieces_out, m_pout);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_last_piece", out_last_piece, q[0].last);
            if (out_ready) begin
                p = q.pop_front();
                m_pout = m_pout + 32'd1;
                if (p.last) m_occ--;
            end
        end else begin
            chk("out_last_idle", out_last_piece, 1'b0);
        end
        if (enq) begin
            for (int k = 0; k < RATIO; k++) begin
                p.d    = rx_data[k*OW +: OW];
                p.last = (k == RATIO - 1);
                q.push_back(p);
            end
            m_occ++;
            m_cin = m_cin + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        logic e;
        for (int i = 0; i < n; i++) cycle(e);
    endtask

    initial begin
        logic          e;
        int            sent;
        int            guard;
        logic [31:0]   base;
        checks   = 0;
        failures = 0;
        model_clear();
        resetb    = 1'b0;
        rx_rdy    = 1'b0;
        rx_data   = '0;
        out_ready = 1'b0;
        #12;
        rx_rdy = 1'b1;
        #1;
        chk("reset_rx_enable", rx_enable, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_last", out_last_piece, 1'b0);
        chk("reset_occupancy", occupancy, 3'd0);
        chk("reset_n_chunks", n_chunks_in, 32'd0);
        chk("reset_n_pieces", n_pieces_out, 32'd0);
        rx_rdy = 1'b0;
        @(posedge clk);
        #1;
        resetb = 1'b1;

        // Single chunk
        rx_rdy    = 1'b1;
        rx_data   = 128'h00000004_00000003_00000002_00000001;
        out_ready = 1'b1;
        cycle(e);
        rx_rdy = 1'b0;
        @(negedge clk);
        chk("single_p0", out_data, 64'h00000002_00000001);
        chk("single_p0_last", out_last_piece, 1'b0);
        @(posedge clk);
        #1;
        m_pout = m_pout + 32'd1;
        void'(q.pop_front());
        run(3);
        chk("single_n_chunks", n_chunks_in, 32'd1);
        chk("single_n_pieces", n_pieces_out, 32'd2);

        // Fill to full with the client stalled
        rx_rdy    = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx_data = {4{$urandom()}} ^ {96'd0, 32'(i)};
            cycle(e);
        end
        chk("fill_occupancy", occupancy, 3'd4);
        chk("fill_n_chunks", n_chunks_in, 32'd5);

        // Drain from full while upstream keeps offering
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            rx_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle(e);
        end
        rx_rdy = 1'b0;
        run(12);

        // Simultaneous last-piece dequeue and enqueue at occupancy 1
        rx_rdy    = 1'b1;
        rx_data   = 128'h11111111_22222222_33333333_44444444;
        out_ready = 1'b0;
        cycle(e);
        rx_rdy    = 1'b0;
        out_ready = 1'b1;
        cycle(e);
        rx_rdy    = 1'b1;
        rx_data   = 128'h55555555_66666666_77777777_88888888;
        cycle(e);
        rx_rdy = 1'b0;
        chk("simul_occupancy", occupancy, 3'd1);
        chk("simul_no_bubble", out_data, 64'h77777777_88888888);
        run(4);

        // Back-pressure toggling over 8 random chunks
        base  = m_pout;
        sent  = 0;
        guard = 0;
        while (sent < 8 && guard < 200) begin
            rx_rdy    = 1'b1;
            rx_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready = guard[0];
            cycle(e);
            if (e) sent++;
            guard++;
        end
        chk("bp_sent_all", sent, 8);
        rx_rdy    = 1'b0;
        out_ready = 1'b1;
        run(20);
        chk("bp_pieces", n_pieces_out - base, 32'd16);

        // Reset mid-chunk
        rx_rdy    = 1'b1;
        rx_data   = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        out_ready = 1'b0;
        cycle(e);
        rx_rdy    = 1'b0;
        out_ready = 1'b1;
        cycle(e);
        rx_rdy    = 1'b1;
        out_ready = 1'b0;
        #2;
        resetb = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_occupancy", occupancy, 3'd0);
        chk("midrst_n_chunks", n_chunks_in, 32'd0);
        chk("midrst_n_pieces", n_pieces_out, 32'd0);
        chk("midrst_rx_enable", rx_enable, 1'b0);
        model_clear();
        @(posedge clk);
        #1;
        resetb  = 1'b1;
        rx_data = {32{4'hA}};
        cycle(e);
        rx_rdy    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_first_piece", out_data, {16{4'hA}});
        chk("midrst_first_last", out_last_piece, 1'b0);
        @(posedge clk);
        #1;
        m_pout = m_pout + 32'd1;
        void'(q.pop_front());
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
